// File: rtl/keypad_emulator.sv
// ----------------------------------------------------------------------------
// keypad_emulator
//   Responder side of a 4x4 matrix keypad. Watches the scanner's active-low
//   row drive and pulls the matching column low while the modelled switch of
//   the requested key is closed. Each press runs through contact bounce, a
//   clean hold, release bounce and a forced open gap before the next press.
//
// Ports
//   clk          in   system clock
//   rst          in   asynchronous reset, active-high
//   fila[3:0]    in   row drive from the scanner, one-hot active-low
//   columna[3:0] out  column sense to the scanner, active-low, idle 4'hF
//   press_req    in   request one press of press_key
//   press_key    in   key index = row*4 + col
//   press_ready  out  high while idle; request accepted on req && ready
//   press_done   out  one-cycle pulse when the press cycle completes
//   contact      out  modelled switch state (1 = closed)
// ----------------------------------------------------------------------------
module keypad_emulator #(
    parameter int unsigned HOLD_CYCLES   = 1_000_000,
    parameter int unsigned BOUNCE_CYCLES = 50_000,
    parameter int unsigned BOUNCE_PERIOD = 4_096,
    parameter int unsigned GAP_CYCLES    = 500_000,
    parameter int unsigned CNT_W         = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    input  logic       press_req,
    input  logic [3:0] press_key,
    output logic       press_ready,
    output logic       press_done,
    output logic       contact
);

    localparam bit               HAS_BOUNCE  = (BOUNCE_CYCLES != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PER_LAST    = CNT_W'(BOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] BOUNCE_LAST =
        HAS_BOUNCE ? CNT_W'(BOUNCE_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        StIdle,
        StBounceIn,
        StHold,
        StBounceOut,
        StGap
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;      // cycles spent in the current phase
    logic [CNT_W-1:0] r_per;      // cycles since the last contact toggle
    logic [3:0]       r_key;
    logic             r_contact;
    logic             r_ready;
    logic             r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_per     <= '0;
            r_key     <= 4'h0;
            r_contact <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (press_req && r_ready) begin
                        r_key     <= press_key;
                        r_ready   <= 1'b0;
                        r_cnt     <= '0;
                        r_per     <= '0;
                        r_contact <= 1'b1;
                        r_state   <= HAS_BOUNCE ? StBounceIn : StHold;
                    end
                end
                StBounceIn, StBounceOut: begin
                    if (r_cnt == BOUNCE_LAST) begin
                        r_cnt <= '0;
                        // Bounce in settles closed, bounce out settles open.
                        r_contact <= (r_state == StBounceIn);
                        r_state   <= (r_state == StBounceIn) ? StHold : StGap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_per == PER_LAST) begin
                            r_per     <= '0;
                            r_contact <= ~r_contact;
                        end else begin
                            r_per <= r_per + 1'b1;
                        end
                    end
                end
                StHold: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt     <= '0;
                        r_per     <= '0;
                        r_contact <= 1'b0;
                        r_state   <= HAS_BOUNCE ? StBounceOut : StGap;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StGap: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Only the requested key's column answers, and only while its row is driven.
    always_comb begin
        columna = 4'hF;
        if (r_contact && !fila[r_key[3:2]]) begin
            columna[r_key[1:0]] = 1'b0;
        end
    end

    assign press_ready = r_ready;
    assign press_done  = r_done;
    assign contact     = r_contact;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int H = 8;
    localparam int P = 2;
    localparam int G = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] fila = 4'hE;
    logic       press_req = 1'b0;
    logic [3:0] press_key = 4'h0;

    logic [3:0] col_a, col_b;
    logic       rdy_a, rdy_b, done_a, done_b, con_a, con_b;

    keypad_emulator #(
        .HOLD_CYCLES(H), .BOUNCE_CYCLES(4), .BOUNCE_PERIOD(P), .GAP_CYCLES(G), .CNT_W(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .fila(fila), .columna(col_a), .press_req(press_req),
        .press_key(press_key), .press_ready(rdy_a), .press_done(done_a), .contact(con_a)
    );

    keypad_emulator #(
        .HOLD_CYCLES(H), .BOUNCE_CYCLES(0), .BOUNCE_PERIOD(P), .GAP_CYCLES(G), .CNT_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .fila(fila), .columna(col_b), .press_req(press_req),
        .press_key(press_key), .press_ready(rdy_b), .press_done(done_b), .contact(con_b)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // Reference model state per DUT (0: bounce 4, 1: no bounce)
    bit         m_busy [2];
    int         m_acc  [2];
    logic [3:0] m_key  [2];
    int         q0[$];
    int         q1[$];

    function automatic int blen(input int d);
        return (d == 0) ? 4 : 0;
    endfunction

    function automatic int plen(input int d);
        return 2 * blen(d) + H + G;
    endfunction

    // Switch state in the j-th cycle after acceptance (j starts at 1).
    function automatic logic exp_contact(input int d, input int j);
        int b;
        b = blen(d);
        if (j < 1 || j > plen(d)) return 1'b0;
        if (j <= b) return (((j - 1) / P) % 2) == 0;
        if (j <= b + H) return 1'b1;
        if (j <= 2 * b + H) return (((j - b - H - 1) / P) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic chk(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, d, cyc, act, exp);
        end
    endtask

    // Model: acceptance and completion bookkeeping at each active edge.
    always @(posedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 1'b0;
            end else if (!m_busy[d]) begin
                if (press_req) begin
                    m_busy[d] = 1'b1;
                    m_acc[d]  = cyc;
                    m_key[d]  = press_key;
                    if (d == 0) q0.push_back(cyc + plen(d));
                    else q1.push_back(cyc + plen(d));
                end
            end else if (cyc == m_acc[d] + plen(d)) begin
                m_busy[d] = 1'b0;
            end
        end
        if (rst) begin
            q0.delete();
            q1.delete();
        end
    end

    // Monitor: compares DUT outputs mid-cycle against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [3:0] a_col, e_col;
            logic       a_rdy, a_done, a_con, e_con;
            int         front;
            a_col  = (d == 0) ? col_a : col_b;
            a_rdy  = (d == 0) ? rdy_a : rdy_b;
            a_done = (d == 0) ? done_a : done_b;
            a_con  = (d == 0) ? con_a : con_b;
            if (rst) begin
                chk("rst_columna", d, 32'(a_col), 32'hF);
                chk("rst_contact", d, 32'(a_con), 32'h0);
                chk("rst_ready", d, 32'(a_rdy), 32'h1);
                chk("rst_done", d, 32'(a_done), 32'h0);
            end else begin
                e_con = m_busy[d] ? exp_contact(d, cyc - m_acc[d] + 1) : 1'b0;
                e_col = 4'hF;
                if (e_con && !fila[m_key[d][3:2]]) e_col[m_key[d][1:0]] = 1'b0;
                chk("columna", d, 32'(a_col), 32'(e_col));
                chk("contact", d, 32'(a_con), 32'(e_con));
                chk("ready", d, 32'(a_rdy), 32'(!m_busy[d]));
                front = -1;
                if (d == 0 && q0.size() > 0) front = q0[0];
                if (d == 1 && q1.size() > 0) front = q1[0];
                if (a_done) begin
                    if (front == -1) begin
                        chk("done_unexpected", d, 32'(a_done), 32'h0);
                    end else begin
                        chk("done_cycle", d, 32'(cyc), 32'(front));
                        if (d == 0) void'(q0.pop_front());
                        else void'(q1.pop_front());
                    end
                end else if (front != -1 && cyc >= front) begin
                    chk("done_missing", d, 32'(a_done), 32'h1);
                    if (d == 0) void'(q0.pop_front());
                    else void'(q1.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_row();
        logic [3:0] rows;
        rows = 4'b1110;
        rows = (rows << $urandom_range(3)) | (rows >> (4 - $urandom_range(3)));
        return 4'hF & ~(4'h1 << $urandom_range(3));
    endfunction

    initial begin
        // Reset with a row driven: everything idle.
        rst  = 1'b1;
        fila = 4'hE;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Key 6 with row 1 held low for the whole press.
        fila      = 4'hD;
        press_key = 4'd6;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        repeat (25) step();

        // Key 0 with row 0, then a request while busy, then a held request.
        fila      = 4'hE;
        press_key = 4'd0;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        repeat (4) step();
        press_key = 4'd3;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        repeat (8) step();
        press_key = 4'd15;
        press_req = 1'b1;
        repeat (10) begin
            fila = rand_row();
            step();
        end
        press_req = 1'b0;
        repeat (25) begin
            fila = rand_row();
            step();
        end

        // Reset in the middle of a press, then a fresh request.
        fila      = 4'hB;
        press_key = 4'd9;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();
        press_key = 4'd5;
        fila      = 4'hD;
        press_req = 1'b1;
        step();
        press_req = 1'b0;
        repeat (25) step();

        // Random traffic, including occasional illegal multi-row drive.
        repeat (1500) begin
            fila      = ($urandom_range(99) < 85) ? rand_row() : 4'($urandom_range(15));
            press_req = ($urandom_range(3) == 0);
            press_key = 4'($urandom_range(15));
            step();
        end
        press_req = 1'b0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
